// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD scanned 7-segment display.
// Segment order is {g,f,e,d,c,b,a}, active-low (common-anode).
package bcd_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'h3F;

  // Digits 0..9, then a dash for every non-BCD code.
  localparam seg7_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_display_scanner.sv
// Latches NUM_DIGITS BCD digits and scans them onto a multiplexed common-anode display,
// inserting one blank cycle per digit switch. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output seg7_t                         seg_n,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          scan_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [NUM_DIGITS-1:0][3:0] dig_sh;
  logic [NUM_DIGITS-1:0]      dp_sh;
  logic [PRE_W-1:0]           prescale;
  logic [NUM_DIGITS-1:0]      an_sel;
  seg7_t                      dec_seg;
  seg7_t                      seg_lit;

  // The display only ever reads the shadow copy, so a load can never tear a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_sh <= '0;
      dp_sh  <= '0;
    end else if (load) begin
      dig_sh <= digits_in;
      dp_sh  <= dp_in;
    end
  end

  assign scan_tick = (prescale == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale  <= '0;
      digit_idx <= '0;
    end else if (scan_tick) begin
      prescale  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      prescale  <= prescale + PRE_W'(1);
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (dig_sh[digit_idx]),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_run;

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run & (dig_sh[i] == 4'd0);
      lz_mask[i] = lz_run;
    end
  end

  assign seg_lit = lz_mask[digit_idx] ? SEG_BLANK : dec_seg;
`else
  assign seg_lit = dec_seg;
`endif

  always_comb begin
    an_sel            = '1;
    an_sel[digit_idx] = 1'b0;
  end

  // The terminal-count cycle becomes the blanking slot that hides the digit switch.
  always_ff @(posedge clk) begin
    if (reset || scan_tick) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= seg_lit;
      dp_n  <= ~dp_sh[digit_idx];
      an_n  <= an_sel;
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream consumer of the decade-counter stages. It takes NUM_DIGITS packed BCD digits, each produced by one counter stage, and latches them on a load strobe. It then drives a time-multiplexed, common-anode 7-segment display: one digit at a time, at a programmable refresh rate, with a blanking slot at every digit switch to suppress ghosting.

## Interface
- NUM_DIGITS, default 4: number of display digits, 2..8; digit 0 is least significant.
- REFRESH_DIV, default 50000: clk cycles per digit slot, ≥ 2.
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- load  in  1  capture digits_in and dp_in into the shadow registers.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit i is bits [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp_n  out  1  decimal point, active-low, registered.
- an_n  out  NUM_DIGITS  digit enables, active-low, one-cold or all-high, registered.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently scanned.
- scan_tick  out  1  one-cycle pulse when the prescaler reaches terminal count.

## Operation
- Shadow registers: when load=1, digits_in and dp_in are captured at the clock edge. Otherwise they hold. The display never reads digits_in directly, so there is no tearing.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0.
  - scan_tick=1 in the cycle where prescaler == REFRESH_DIV-1.
  - On that cycle's edge, digit_idx advances by 1, and from NUM_DIGITS-1 it wraps to 0.
- Decode of shadow digit[digit_idx], in seg_n hex:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10.
  - Non-BCD values 10..15 decode to dash 7'h3F (g only).
- Output register: each cycle, seg_n, dp_n and an_n are loaded from that cycle's digit_idx and shadow contents.
  - When scan_tick=1, the next-cycle an_n is all ones, seg_n = 7'h7F and dp_n = 1. This is the blanking slot.
  - Otherwise an_n has bit digit_idx low, and dp_n = ~dp_shadow[digit_idx].
- Reset values: shadow digits 0, dp shadow 0, prescaler 0, digit_idx 0, seg_n 7'h7F, dp_n 1, an_n all ones, scan_tick 0.
- Reset mid-scan: state returns to the reset values at the next edge, and any partial slot is discarded.
- load coinciding with scan_tick: both take effect at the same edge. The new shadow value is visible from the first non-blank cycle of the next slot.

## Timing
- Latency from load to seg_n: 2 cycles. Shadow updates at edge t+1; seg_n reflects it at edge t+2 if that digit is selected.
- Latency from digit_idx to an_n/seg_n: 1 cycle.
- Slot length is REFRESH_DIV cycles: 1 blank cycle plus REFRESH_DIV-1 lit cycles.
- Full frame is NUM_DIGITS*REFRESH_DIV cycles.
- First lit cycle after reset release: digit 0 shows 7'h40, one cycle after reset deasserts.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Shadow digits equal to 0, from NUM_DIGITS-1 downward until the first nonzero digit, display seg_n 7'h7F with an_n still asserted.
  - Their dp is still honoured.
  - Digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: every digit is decoded normally, and leading zeros show 7'h40.

## Structure
- Package bcd_display_pkg holds:
  - seg7_t (logic [6:0]).
  - Constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F.
  - The 16-entry decode constant table.
- Sub-module bcd_to_seg7: purely combinational, 4-bit BCD in, seg7_t out. It is instantiated once on the muxed digit.
- The leading-zero mask is combinational logic over the shadow registers, inside the top module.

## Test plan
Bench uses NUM_DIGITS=4 and REFRESH_DIV=4.
- Reset, then idle: an_n cycles 1110, 1111 (blank), 1101, ..., always with seg_n 7'h40; scan_tick every 4th cycle.
- load with digits_in=16'h1905, dp_in=4'b0100: during digit-2 lit cycles, seg_n=7'h10 and dp_n=0; during digit-0 lit cycles, seg_n=7'h12 and dp_n=1.
- digits_in=16'h00A7: digit 1 shows 7'h3F (dash), digit 0 shows 7'h78.
- LEADING_ZERO_BLANK_EN with 16'h0030: digits 3 and 2 show 7'h7F, digit 1 shows 7'h30, digit 0 shows 7'h40. With 16'h0000: only digit 0 shows 7'h40.
- load in the same cycle as scan_tick: the new value appears on the first lit cycle of the next slot, and nothing appears during the blank cycle.
- reset asserted mid-slot at digit 2: the next edge gives an_n=1111, digit_idx=0 and shadow cleared; scanning restarts at digit 0.
